// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types, constants and helpers for the seven-segment scan driver.
//   state_t         : scan FSM states (BLANK, DRIVE)
//   SEG_W           : segment bus width {g,f,e,d,c,b,a}
//   SEG_OFF_LOGICAL : logical "all segments dark" pattern
//   apply_pol()     : maps a logical pattern (1 = lit) to the physical drive level
package sseg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF_LOGICAL = 7'h00;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Active-low outputs take the inverted logical pattern.
  function automatic logic [SEG_W-1:0] apply_pol(input logic [SEG_W-1:0] value,
                                                 input logic             active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/sseg_digit_regfile.sv
// sseg_digit_regfile: NUM_DIGITS x 7-bit pattern store written from a
// software-toggled strobe PIO.
//   clk, reset : clock, synchronous active-high reset
//   wr_val     : pattern to store (logical polarity)
//   wr_addr    : target digit; indices >= NUM_DIGITS are ignored
//   wr_strobe  : strobe level; only a 0->1 transition commits a write
//   rd_idx     : combinational read index
//   rd_data    : pattern stored at rd_idx (0 for an out-of-range index)
module sseg_digit_regfile
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int AW         = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEG_W-1:0] wr_val,
  input  logic [AW-1:0]    wr_addr,
  input  logic             wr_strobe,
  input  logic [AW-1:0]    rd_idx,
  output logic [SEG_W-1:0] rd_data
);

  // One spare bit so NUM_DIGITS == 2**AW does not wrap to zero.
  localparam logic [AW:0] ADDR_LIM = (AW + 1)'(NUM_DIGITS);

  logic [SEG_W-1:0] digit_r [NUM_DIGITS];
  logic             strobe_q_r;
  logic             commit_s;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Edge detect on the strobe level and address range checks.
  always_comb begin
    commit_s = wr_strobe & ~strobe_q_r;
    wr_ok_s  = ({1'b0, wr_addr} < ADDR_LIM);
    rd_ok_s  = ({1'b0, rd_idx} < ADDR_LIM);
  end

  // Strobe history and pattern storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q_r <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_r[i] <= SEG_OFF_LOGICAL;
      end
    end else begin
      strobe_q_r <= wr_strobe;
      if (commit_s && wr_ok_s) begin
        digit_r[wr_addr] <= wr_val;
      end
    end
  end

  // Combinational read port.
  always_comb begin
    if (rd_ok_s) begin
      rd_data = digit_r[rd_idx];
    end else begin
      rd_data = SEG_OFF_LOGICAL;
    end
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexes per-digit segment patterns onto a shared
// segment bus with a one-hot digit enable and a blanking gap between digits.
//   clk, reset  : clock, synchronous active-high reset
//   wr_val      : pattern {g,f,e,d,c,b,a}, 1 = lit
//   wr_addr     : target digit index
//   wr_strobe   : strobe PIO level, rising edge commits the write
//   brightness  : 4-bit duty control (only with SSEG_SCAN_DIMMING_EN defined)
//   seg_out     : physical segment drive (registered)
//   dig_out     : physical digit enables, at most one active (registered)
//   frame_tick  : one-cycle pulse after the last digit's slot ends
// Optional feature macro: SSEG_SCAN_DIMMING_EN gates dig_out with a 16-step PWM.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  localparam int AW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEG_W-1:0]      wr_val,
  input  logic [AW-1:0]         wr_addr,
  input  logic                  wr_strobe,
`ifdef SSEG_SCAN_DIMMING_EN
  input  logic [3:0]            brightness,
`endif
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] dig_out,
  output logic                  frame_tick
);

  localparam int                    SW         = $clog2(SCAN_DIV);
  localparam logic [SW-1:0]         SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]         BLANK_LAST = SW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0]         IDX_LAST   = AW'(NUM_DIGITS - 1);
  localparam logic                  SEG_AL     = (SEG_ACTIVE_LOW != 0);
  localparam logic                  DIG_AL     = (DIG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF    = DIG_AL ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  state_t                  state_r, state_nxt_s;
  logic [SW-1:0]           slot_cnt_r, slot_nxt_s;
  logic [AW-1:0]           dig_idx_r, dig_idx_nxt_s;
  logic [SEG_W-1:0]        seg_lat_r, seg_lat_nxt_s;
  logic                    frame_nxt_s;
  logic                    slot_wrap_s;
  logic                    dig_en_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [SEG_W-1:0]        rd_data_s;

  sseg_digit_regfile #(
    .NUM_DIGITS (NUM_DIGITS),
    .AW         (AW)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_val    (wr_val),
    .wr_addr   (wr_addr),
    .wr_strobe (wr_strobe),
    .rd_idx    (dig_idx_r),
    .rd_data   (rd_data_s)
  );

  // Next-state logic for the slot counter and BLANK/DRIVE sequencing.
  always_comb begin
    state_nxt_s   = state_r;
    dig_idx_nxt_s = dig_idx_r;
    seg_lat_nxt_s = seg_lat_r;
    frame_nxt_s   = 1'b0;
    slot_wrap_s   = (slot_cnt_r == SLOT_LAST);
    if (slot_wrap_s) begin
      slot_nxt_s = '0;
    end else begin
      slot_nxt_s = slot_cnt_r + SW'(1);
    end
    case (state_r)
      BLANK: begin
        // Pattern is frozen here, so later writes cannot glitch this slot.
        if (slot_cnt_r == BLANK_LAST) begin
          state_nxt_s   = DRIVE;
          seg_lat_nxt_s = rd_data_s;
        end else begin
          state_nxt_s = BLANK;
        end
      end
      DRIVE: begin
        if (slot_wrap_s) begin
          state_nxt_s = BLANK;
          if (dig_idx_r == IDX_LAST) begin
            dig_idx_nxt_s = '0;
            frame_nxt_s   = 1'b1;
          end else begin
            dig_idx_nxt_s = dig_idx_r + AW'(1);
          end
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      default: begin
        state_nxt_s = BLANK;
      end
    endcase
  end

`ifdef SSEG_SCAN_DIMMING_EN
  logic [3:0] pwm_cnt_r;

  // Free-running PWM phase used to gate the digit enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_r <= 4'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 4'd1;
    end
  end
`endif

  // Digit-enable decode for the cycle being registered.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot_s[i] = (dig_idx_nxt_s == AW'(i));
    end
`ifdef SSEG_SCAN_DIMMING_EN
    if (state_nxt_s == DRIVE) begin
      dig_en_s = (pwm_cnt_r < brightness);
    end else begin
      dig_en_s = 1'b0;
    end
`else
    dig_en_s = (state_nxt_s == DRIVE);
`endif
  end

  // Scan state and registered physical outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= BLANK;
      slot_cnt_r <= '0;
      dig_idx_r  <= '0;
      seg_lat_r  <= SEG_OFF_LOGICAL;
      frame_tick <= 1'b0;
      seg_out    <= apply_pol(SEG_OFF_LOGICAL, SEG_AL);
      dig_out    <= DIG_OFF;
    end else begin
      state_r    <= state_nxt_s;
      slot_cnt_r <= slot_nxt_s;
      dig_idx_r  <= dig_idx_nxt_s;
      seg_lat_r  <= seg_lat_nxt_s;
      frame_tick <= frame_nxt_s;
      if (state_nxt_s == DRIVE) begin
        seg_out <= apply_pol(seg_lat_nxt_s, SEG_AL);
      end else begin
        seg_out <= apply_pol(SEG_OFF_LOGICAL, SEG_AL);
      end
      if (dig_en_s) begin
        dig_out <= DIG_AL ? ~onehot_s : onehot_s;
      end else begin
        dig_out <= DIG_OFF;
      end
    end
  end

endmodule
